// File: rtl/acc_requant_pkg.sv
`default_nettype none
// ============================================================================
// Module      : acc_requant_pkg
// Description : Shared types, default widths and the shift/round/saturate
//               helper for the accumulator requantize-and-pack stage.
// Revision    : 1.0 - initial release
// ============================================================================
package acc_requant_pkg;

  localparam int DEF_ACC_W = 32;
  localparam int DEF_OUT_W = 8;
  localparam int DEF_PACK  = 4;
  localparam int SHIFT_W   = 5;
  localparam int LEN_W     = 16;
  // Working width for the rounding add; holds ACC_W+1 bits for any ACC_W <= 63.
  localparam int CALC_W    = 64;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  // Rounding arithmetic right shift (half toward +inf) followed by signed
  // saturation to an out_w-bit range. Result is returned sign-extended.
  function automatic logic signed [CALC_W-1:0] sat_round(
    input logic signed [CALC_W-1:0] acc,
    input logic        [SHIFT_W-1:0] shift,
    input int                        out_w
  );
    logic signed [CALC_W-1:0] half;
    logic signed [CALC_W-1:0] sum;
    logic signed [CALC_W-1:0] shifted;
    logic signed [CALC_W-1:0] hi;
    logic signed [CALC_W-1:0] lo;
    half = '0;
    if (shift != '0) begin
      half = CALC_W'(1) << (shift - SHIFT_W'(1));
    end
    sum     = acc + half;
    shifted = sum >>> shift;
    hi      = (CALC_W'(1) << (out_w - 1)) - CALC_W'(1);
    lo      = ~hi;
    if (shifted > hi) begin
      sat_round = hi;
    end else if (shifted < lo) begin
      sat_round = lo;
    end else begin
      sat_round = shifted;
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/acc_requant_packer_requant_lane.sv
`default_nettype none
// ============================================================================
// Module      : requant_lane
// Description : Combinational conversion of one signed accumulator value to
//               an OUT_W-bit element: rounding shift, optional ReLU, saturate.
//               Optional feature macro: ACC_REQUANT_RELU_EN (clamp negatives).
// Revision    : 1.0 - initial release
// ============================================================================
module requant_lane
  import acc_requant_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W,
  parameter int OUT_W = DEF_OUT_W
) (
  input  logic signed [ACC_W-1:0]   acc,
  input  logic        [SHIFT_W-1:0] shift,
  output logic signed [OUT_W-1:0]   res
);

  // Saturated value already fits OUT_W, so its top bit is the true sign;
  // clamping after saturation gives the same result as clamping before.
  always_comb begin
    res = OUT_W'(sat_round(CALC_W'(acc), shift, OUT_W));
`ifdef ACC_REQUANT_RELU_EN
    if (res[OUT_W-1]) begin
      res = '0;
    end
`endif
  end

endmodule
`default_nettype wire

// File: rtl/acc_requant_packer.sv
`default_nettype none
// ============================================================================
// Module      : acc_requant_packer
// Description : Requantizes a stream of signed accumulators to OUT_W-bit
//               elements, packs PACK elements per output beat and marks the
//               last beat of each cfg_len-element frame with m_TLAST.
//               Optional feature macro: ACC_REQUANT_RELU_EN (ReLU clamp).
// Revision    : 1.0 - initial release
// ============================================================================
module acc_requant_packer
  import acc_requant_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int PACK  = DEF_PACK
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ACC_W-1:0]      s_TDATA,
  input  logic                  s_TVALID,
  output logic                  s_TREADY,
  input  logic [SHIFT_W-1:0]    cfg_shift,
  input  logic [LEN_W-1:0]      cfg_len,
  output logic [PACK*OUT_W-1:0] m_TDATA,
  output logic [PACK-1:0]       m_TKEEP,
  output logic                  m_TLAST,
  output logic                  m_TVALID,
  input  logic                  m_TREADY
);

  localparam int LANE_W = (PACK > 1) ? $clog2(PACK) : 1;
  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(PACK - 1);

  state_t              state;
  state_t              state_nxt;
  logic [LANE_W-1:0]   lane;
  logic [LANE_W-1:0]   lane_nxt;
  logic [LEN_W-1:0]    elem;
  logic [LEN_W-1:0]    elem_nxt;
  logic [SHIFT_W-1:0]  shift_reg;
  logic [LEN_W-1:0]    len_m1_reg;
  logic [OUT_W-1:0]    lane_buf [PACK];

  logic                accept;
  logic                frame_last;
  logic                beat_done;
  logic [SHIFT_W-1:0]  eff_shift;
  logic [LEN_W-1:0]    eff_len_m1;
  logic signed [OUT_W-1:0] new_elem;
  logic [PACK*OUT_W-1:0]   beat_data;
  logic [PACK-1:0]         beat_keep;

  // Stall whenever the output register holds a beat that is not draining.
  assign s_TREADY = !m_TVALID || m_TREADY;
  assign accept   = s_TVALID && s_TREADY;

  // Frame parameters: live config for a frame's first element, latched after.
  always_comb begin
    eff_shift  = shift_reg;
    eff_len_m1 = len_m1_reg;
    if (state == IDLE) begin
      eff_shift  = cfg_shift;
      eff_len_m1 = (cfg_len == '0) ? '0 : cfg_len - LEN_W'(1);
    end
  end

  assign frame_last = (elem == eff_len_m1);
  assign beat_done  = (lane == LANE_LAST) || frame_last;

  requant_lane #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W)
  ) u_requant_lane (
    .acc   (s_TDATA),
    .shift (eff_shift),
    .res   (new_elem)
  );

  // Next frame state and element/lane counters.
  always_comb begin
    state_nxt = state;
    lane_nxt  = lane;
    elem_nxt  = elem;
    if (accept) begin
      if (frame_last) begin
        state_nxt = IDLE;
        lane_nxt  = '0;
        elem_nxt  = '0;
      end else begin
        state_nxt = FILL;
        lane_nxt  = beat_done ? '0 : lane + LANE_W'(1);
        elem_nxt  = elem + LEN_W'(1);
      end
    end
  end

  // Merge buffered lanes with the incoming element; lanes above it stay zero.
  always_comb begin
    beat_data = '0;
    beat_keep = '0;
    for (int i = 0; i < PACK; i++) begin
      if (LANE_W'(i) < lane) begin
        beat_data[i*OUT_W +: OUT_W] = lane_buf[i];
        beat_keep[i]                = 1'b1;
      end else if (LANE_W'(i) == lane) begin
        beat_data[i*OUT_W +: OUT_W] = new_elem;
        beat_keep[i]                = 1'b1;
      end
    end
  end

  // FSM state and counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      lane  <= '0;
      elem  <= '0;
    end else begin
      state <= state_nxt;
      lane  <= lane_nxt;
      elem  <= elem_nxt;
    end
  end

  // Capture shift/length on the first element of each frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_reg  <= '0;
      len_m1_reg <= '0;
    end else if (accept && (state == IDLE)) begin
      shift_reg  <= cfg_shift;
      len_m1_reg <= eff_len_m1;
    end
  end

  // Lane buffer holds elements of the beat still being filled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < PACK; i++) begin
        lane_buf[i] <= '0;
      end
    end else if (accept && !beat_done) begin
      lane_buf[lane] <= new_elem;
    end
  end

  // Output register: loads a completed beat, even while the previous one drains.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_TDATA  <= '0;
      m_TKEEP  <= '0;
      m_TLAST  <= 1'b0;
      m_TVALID <= 1'b0;
    end else if (accept && beat_done) begin
      m_TDATA  <= beat_data;
      m_TKEEP  <= beat_keep;
      m_TLAST  <= frame_last;
      m_TVALID <= 1'b1;
    end else if (m_TREADY) begin
      m_TVALID <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_acc_requant_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_acc_requant_packer
// Description : Randomized self-checking bench for acc_requant_packer with a
//               frame-level reference model (ACC_W=32, OUT_W=8, PACK=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_acc_requant_packer;

  localparam int ACC_W = 32;
  localparam int OUT_W = 8;
  localparam int PACK  = 4;

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic [ACC_W-1:0]      s_tdata = '0;
  logic                  s_tvalid = 1'b0;
  logic                  s_tready;
  logic [4:0]            cfg_shift = '0;
  logic [15:0]           cfg_len = '0;
  logic [PACK*OUT_W-1:0] m_tdata;
  logic [PACK-1:0]       m_tkeep;
  logic                  m_tlast;
  logic                  m_tvalid;
  logic                  m_tready = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;

  int                    facc[$];
  logic [PACK*OUT_W-1:0] exp_data[$];
  logic [PACK-1:0]       exp_keep[$];
  logic                  exp_last[$];

  acc_requant_packer #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W),
    .PACK  (PACK)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .s_TDATA   (s_tdata),
    .s_TVALID  (s_tvalid),
    .s_TREADY  (s_tready),
    .cfg_shift (cfg_shift),
    .cfg_len   (cfg_len),
    .m_TDATA   (m_tdata),
    .m_TKEEP   (m_tkeep),
    .m_TLAST   (m_tlast),
    .m_TVALID  (m_tvalid),
    .m_TREADY  (m_tready)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (got hang, expected finish)");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference requantization using floor division of the rounded value.
  function automatic int model_q(input int acc, input int sh);
    longint d;
    longint v;
    longint q;
    d = longint'(1) << sh;
    v = longint'(acc) + ((sh > 0) ? d / 2 : 0);
    q = v / d;
    if ((v % d) != 0 && v < 0) q = q - 1;
`ifdef ACC_REQUANT_RELU_EN
    if (q < 0) q = 0;
`endif
    if (q > 127) q = 127;
    if (q < -128) q = -128;
    return int'(q);
  endfunction

  // Expected beats of one whole frame, chunked PACK elements at a time.
  task automatic build_expected(input int len, input int sh);
    logic [PACK*OUT_W-1:0] d;
    logic [PACK-1:0]       k;
    int                    q;
    d = '0;
    k = '0;
    for (int e = 0; e < len; e++) begin
      q = model_q(facc[e], sh);
      d[(e % PACK)*OUT_W +: OUT_W] = q[OUT_W-1:0];
      k[e % PACK] = 1'b1;
      if ((e % PACK) == PACK - 1 || e == len - 1) begin
        exp_data.push_back(d);
        exp_keep.push_back(k);
        exp_last.push_back(e == len - 1);
        d = '0;
        k = '0;
      end
    end
  endtask

  // mode 0: valid/ready always high; 1: random gaps; 2: 5-cycle stall on first beat.
  task automatic run_frame(input int len_cfg, input int sh, input int mode);
    int                    len;
    int                    idx;
    int                    cyc;
    int                    stall_left;
    bit                    stall_done;
    bit                    in_stall;
    bit                    have_hold;
    bit                    vld;
    logic [PACK*OUT_W-1:0] hold_d;
    len        = (len_cfg == 0) ? 1 : len_cfg;
    idx        = 0;
    cyc        = 0;
    stall_left = 0;
    stall_done = 0;
    have_hold  = 0;
    vld        = 0;
    build_expected(len, sh);
    while ((idx < len || exp_data.size() > 0) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (mode == 2 && !stall_done && m_tvalid) begin
        stall_done = 1;
        stall_left = 5;
      end
      in_stall = 0;
      if (stall_left > 0) begin
        m_tready = 1'b0;
        stall_left--;
        in_stall = 1;
      end else if (mode == 1) begin
        m_tready = ($urandom_range(0, 3) != 0);
      end else begin
        m_tready = 1'b1;
      end
      if (idx < len) begin
        if (!vld) vld = (mode != 1) || ($urandom_range(0, 3) != 0);
        s_tvalid  = vld;
        s_tdata   = facc[idx];
        cfg_shift = (idx == 0) ? 5'(sh) : 5'($urandom);
        cfg_len   = (idx == 0) ? 16'(len_cfg) : 16'($urandom);
      end else begin
        s_tvalid = 1'b0;
        s_tdata  = $urandom;
      end
      #1;
      check_val("ready_rule", s_tready, !m_tvalid || m_tready);
      if (in_stall) begin
        check_val("stall_s_ready", s_tready, 0);
        check_val("stall_valid", m_tvalid, 1);
        if (have_hold) check_val("stall_data", m_tdata, hold_d);
        hold_d    = m_tdata;
        have_hold = 1;
      end
      if (m_tvalid && m_tready) begin
        if (exp_data.size() == 0) begin
          check_val("spurious_beat", 1, 0);
        end else begin
          check_val("beat_data", m_tdata, exp_data.pop_front());
          check_val("beat_keep", m_tkeep, exp_keep.pop_front());
          check_val("beat_last", m_tlast, exp_last.pop_front());
        end
      end
      if (s_tvalid && s_tready) begin
        idx++;
        vld = 0;
      end
    end
    if (cyc >= 2000) begin
      check_val("frame_timeout", 0, 1);
      exp_data.delete();
      exp_keep.delete();
      exp_last.delete();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_s_ready"}, s_tready, 1);
    check_val({tag, "_m_valid"}, m_tvalid, 0);
    check_val({tag, "_m_data"},  m_tdata, 0);
    check_val({tag, "_m_keep"},  m_tkeep, 0);
    check_val({tag, "_m_last"},  m_tlast, 0);
  endtask

  initial begin
    int len;
    int sh;
    int a;
    #1;
    check_reset_outputs("rst");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_outputs("post_rst");

    // Rounding, half toward +inf.
    facc = {311};
    run_frame(1, 4, 0);
    facc = {-40};
    run_frame(1, 2, 0);
    // Saturation both ways.
    facc = {100000, -100000};
    run_frame(2, 4, 0);
    // Full frame of two beats.
    facc = {};
    for (int i = 1; i <= 8; i++) facc.push_back(16 * i);
    run_frame(8, 4, 0);
    // Partial final beat.
    facc = {};
    for (int i = 0; i < 6; i++) facc.push_back(int'($urandom_range(0, 4000)) - 2000);
    run_frame(6, 4, 0);
    // Backpressure right after the first beat.
    facc = {};
    for (int i = 0; i < 8; i++) facc.push_back(int'($urandom_range(0, 4000)) - 2000);
    run_frame(8, 3, 2);
    // Zero length behaves as one.
    facc = {1234};
    run_frame(0, 0, 0);

    // Reset after 3 of 8 elements: partial beat must vanish.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      m_tready  = 1'b1;
      s_tvalid  = 1'b1;
      s_tdata   = 32'(100 * (k + 1));
      cfg_shift = 5'd2;
      cfg_len   = 16'd8;
      #1;
      check_val("mid_s_ready", s_tready, 1);
    end
    @(negedge clk);
    s_tvalid = 1'b0;
    #1;
    check_val("mid_no_beat", m_tvalid, 0);
    reset = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    @(negedge clk);
    reset = 1'b1;
    facc = {};
    for (int i = 0; i < 5; i++) facc.push_back(int'($urandom_range(0, 2000)) - 1000);
    run_frame(5, 1, 0);

    // Random frames.
    for (int f = 0; f < 40; f++) begin
      len = $urandom_range(0, 13);
      sh  = $urandom_range(0, 31);
      facc = {};
      for (int i = 0; i < ((len == 0) ? 1 : len); i++) begin
        if ($urandom_range(0, 1) == 0) a = $urandom;
        else a = int'($urandom_range(0, 20000)) - 10000;
        facc.push_back(a);
      end
      run_frame(len, sh, $urandom_range(0, 2));
    end

    @(negedge clk);
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_val("idle_valid", m_tvalid, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
